// File: rtl/dual_wb_regfile_pkg.sv
// Shared types for the dual-issue writeback/decode boundary.
// Writeback bundle, decode operand bundle and control encodings.
package dual_wb_regfile_pkg;

  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    CTRL_NONE = 2'd0,
    REG_WRITE = 2'd1,
    MEM_WRITE = 2'd2,
    CTRL_RSVD = 2'd3
  } control_signal_t;

  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [REG_ADDR_W-1:0] rd;
    control_signal_t       we;
  } wb_per_t;

  typedef struct packed {
    wb_per_t A;
    wb_per_t B;
  } wb_t;

  typedef struct packed {
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
  } regs_per_t;

  typedef struct packed {
    regs_per_t one;
    regs_per_t two;
  } regs_t;

  function automatic logic lane_writes(wb_per_t l);
    return (l.we == REG_WRITE) && (l.rd != ZERO_REG);
  endfunction

endpackage

// File: rtl/dual_wb_regfile_read_port.sv
// One decode read port: x0, then lane B bypass, then lane A bypass,
// then the stored value.
module regfile_read_port
  import dual_wb_regfile_pkg::*;
#(
  parameter int DATA_W    = XLEN,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic                  addr_ok,
  input  logic [DATA_W-1:0]     stored,
  input  logic                  we_a,
  input  logic                  we_b,
  input  wb_t                   wb,
  output logic [DATA_W-1:0]     data
);

  always_comb begin
    data = '0;
    if (!rst_n || addr == ZERO_REG || !addr_ok)
      data = '0;
    else if (BYPASS_EN && we_b && wb.B.rd == addr)
      data = wb.B.data;
    else if (BYPASS_EN && we_a && wb.A.rd == addr)
      data = wb.A.data;
    else
      data = stored;
  end

endmodule

// File: rtl/dual_wb_regfile.sv
// Architectural register file: two writeback lanes, four decode
// read ports with same-cycle bypass; lane B is younger and wins.
module dual_wb_regfile
  import dual_wb_regfile_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int DATA_W    = XLEN,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  wb_t                   wb_i,
  input  logic [REG_ADDR_W-1:0] rs1_A,
  input  logic [REG_ADDR_W-1:0] rs2_A,
  input  logic [REG_ADDR_W-1:0] rs1_B,
  input  logic [REG_ADDR_W-1:0] rs2_B,
  output regs_t                 regs_o,
  output logic                  wr_collide_o
);

  localparam int NSLOT = 1 << REG_ADDR_W;

  logic [DATA_W-1:0]     rf [NSLOT];
  logic                  we_a;
  logic                  we_b;
  logic [REG_ADDR_W-1:0] addr [4];
  logic [DATA_W-1:0]     rdata [4];

  function automatic logic in_range(logic [REG_ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  assign we_a = rst_n && lane_writes(wb_i.A) && in_range(wb_i.A.rd);
  assign we_b = rst_n && lane_writes(wb_i.B) && in_range(wb_i.B.rd);

  // B assigned last so it overwrites A on a same-rd collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++)
        rf[i] <= '0;
      wr_collide_o <= 1'b0;
    end else begin
      if (we_a)
        rf[wb_i.A.rd] <= wb_i.A.data;
      if (we_b)
        rf[wb_i.B.rd] <= wb_i.B.data;
      wr_collide_o <= we_a && we_b && (wb_i.A.rd == wb_i.B.rd);
    end
  end

  assign addr[0] = rs1_A;
  assign addr[1] = rs2_A;
  assign addr[2] = rs1_B;
  assign addr[3] = rs2_B;

  for (genvar g = 0; g < 4; g++) begin : g_rd
    regfile_read_port #(
      .DATA_W    (DATA_W),
      .BYPASS_EN (BYPASS_EN)
    ) u_port (
      .rst_n   (rst_n),
      .addr    (addr[g]),
      .addr_ok (in_range(addr[g])),
      .stored  (rf[addr[g]]),
      .we_a    (we_a),
      .we_b    (we_b),
      .wb      (wb_i),
      .data    (rdata[g])
    );
  end

  assign regs_o.one.A = rdata[0];
  assign regs_o.one.B = rdata[1];
  assign regs_o.two.A = rdata[2];
  assign regs_o.two.B = rdata[3];

endmodule
